// File: rtl/fa_pkg.sv
// fa_pkg: shared state encoding, vector bit layout and golden full-adder model
// for the full-adder BIST engine.
package fa_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, CHECK, DONE} state_e;

    localparam int VEC_B   = 0;
    localparam int VEC_A   = 1;
    localparam int VEC_CIN = 2;
    localparam int NUM_VEC = 8;

    // Returns {sum, carry}; kept independent of any fulladder instance.
    function automatic logic [1:0] fa_golden(input logic [2:0] vec);
        logic a, b, c;
        a = vec[VEC_A];
        b = vec[VEC_B];
        c = vec[VEC_CIN];
        return {a ^ b ^ c, (a & b) | (a & c) | (b & c)};
    endfunction

endpackage

// File: rtl/fa_bist_if.sv
// fa_bist_if: run control, cell stimulus/response and result signals of the
// full-adder BIST; master is the BIST engine, slave its environment.
interface fa_bist_if;

    logic       start;
    logic       fa_a;
    logic       fa_b;
    logic       fa_cin;
    logic       fa_sum;
    logic       fa_carry;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [2:0] first_err_vec;
    logic [1:0] first_err_obs;

    modport master (
        input  start, fa_sum, fa_carry,
        output fa_a, fa_b, fa_cin, busy, done, pass,
        output err_count, first_err_vec, first_err_obs
    );

    modport slave (
        output start, fa_sum, fa_carry,
        input  fa_a, fa_b, fa_cin, busy, done, pass,
        input  err_count, first_err_vec, first_err_obs
    );

endinterface

// File: rtl/fa_bist.sv
// fa_bist: applies all 8 full-adder input vectors, samples the cell after SETTLE
// cycles and reports pass, mismatch count and the first failing vector.
module fa_bist
    import fa_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input logic    clk,
    input logic    rst_n,
    fa_bist_if.master bus
);

    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);
    localparam logic [2:0] VEC_LAST = 3'(NUM_VEC - 1);

    state_e     state_q, state_d;
    logic [2:0] vec_q, vec_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] err_q, err_d;
    logic [2:0] fv_q, fv_d;
    logic [1:0] fo_q, fo_d;
    logic       pass_q, pass_d;
    logic [1:0] obs;
    logic       mism;

    // The vector register doubles as the registered stimulus to the cell.
    assign bus.fa_a          = vec_q[VEC_A];
    assign bus.fa_b          = vec_q[VEC_B];
    assign bus.fa_cin        = vec_q[VEC_CIN];
    assign bus.busy          = (state_q == WAIT) || (state_q == CHECK);
    assign bus.done          = (state_q == DONE);
    assign bus.pass          = pass_q;
    assign bus.err_count     = err_q;
    assign bus.first_err_vec = fv_q;
    assign bus.first_err_obs = fo_q;

    assign obs  = {bus.fa_sum, bus.fa_carry};
    assign mism = (obs != fa_golden(vec_q));

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        fv_d    = fv_q;
        fo_d    = fo_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: if (bus.start) begin
                vec_d   = '0;
                cnt_d   = CNT_INIT;
                err_d   = '0;
                fv_d    = '0;
                fo_d    = '0;
                pass_d  = 1'b0;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == '0) state_d = CHECK;
                else cnt_d = cnt_q - 4'd1;
            end
            CHECK: begin
                if (mism) begin
                    err_d = err_q + 4'd1;
                    if (err_q == '0) begin
                        fv_d = vec_q;
                        fo_d = obs;
                    end
                end
                if (vec_q == VEC_LAST) begin
                    pass_d  = (err_d == '0);
                    state_d = DONE;
                end else begin
                    vec_d   = vec_q + 3'd1;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            err_q   <= '0;
            fv_q    <= '0;
            fo_q    <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            fo_q    <= fo_d;
            pass_q  <= pass_d;
        end
    end

endmodule
